pipe_stage_buf: RTL

Parametrised pipeline stage register with valid/ready handshake, two-entry skid buffer and synchronous flush. It generalises the fixed MEM/WB-style latch: any stage boundary gets a DATA_W-wide payload register plus stall and bubble handling. Each instance sits between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It cuts the combinational ready path and exposes a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_stage_buf.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: state encoding and occupancy helpers.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Number of payloads held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      ST_ONE:  occ_of = OCC_W'(1);
      ST_TWO:  occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned CLEAR_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [OCC_W-1:0]  occupancy
);

  localparam bit CLR_EN = (CLEAR_ON_FLUSH != 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OCC_W-1:0]   r_occ;
  logic [DATA_W-1:0]  r_main;
  logic [DATA_W-1:0]  r_skid;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_main;
  logic w_load_skid;
  logic w_main_from_skid;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Handshake flags and occupancy are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_occ       <= occ_of(w_state_nxt);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_in_xfer, w_out_xfer})
          2'b11: w_load_main = 1'b1;
          2'b10: begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_TWO;
          end
          2'b01: w_state_nxt = ST_EMPTY;
          default: ;
        endcase
      end
      ST_TWO: begin
        if (w_out_xfer) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Squash drops every held payload and any input accepted this cycle.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush && CLR_EN) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (r_out_valid && !out_ready),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;

endmodule
